// File: rtl/vec_pkg.sv
// Shared constants, operand struct and FSM encoding for the vector scaler.
package vec_pkg;
  localparam int W    = 19;
  localparam int FRAC = 8;

  localparam logic signed [W-1:0] SMAX = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] SMIN = {1'b1, {(W-1){1'b0}}};

  localparam int X_LSB = 2*W;
  localparam int Y_LSB = W;
  localparam int Z_LSB = 0;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_MX   = 3'd1;
  localparam logic [2:0] S_MY   = 3'd2;
  localparam logic [2:0] S_MZ   = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  typedef struct packed {
    logic [W-1:0]   scl;
    logic [3*W-1:0] vec;
  } vs_req_t;
endpackage

// File: rtl/sat_mul_shift.sv
// Signed Q-format multiply, optional round-half-up, arithmetic shift, saturate.
// Rounding is enabled by defining VECTOR_SCALE_ROUND_EN.
module sat_mul_shift
  import vec_pkg::*;
(
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  output logic signed [W-1:0] r,
  output logic                sat
);
  logic signed [2*W-1:0] p;
  logic signed [2*W:0]   pe;
  logic signed [2*W:0]   q;
  logic                  hi, lo;

  assign p = a * b;

`ifdef VECTOR_SCALE_ROUND_EN
  // one guard bit so the half-LSB add can never wrap
  localparam logic signed [2*W:0] HALF = (2*W+1)'(1) << (FRAC-1);
  assign pe = {p[2*W-1], p} + HALF;
`else
  assign pe = {p[2*W-1], p};
`endif

  assign q = pe >>> FRAC;

  // in range only when every bit above the result sign matches q's sign
  assign hi  = !q[2*W] &&  (|q[2*W-1:W-1]);
  assign lo  =  q[2*W] && !(&q[2*W-1:W-1]);
  assign sat = hi | lo;
  assign r   = hi ? SMAX : (lo ? SMIN : q[W-1:0]);
endmodule

// File: rtl/vector_scale_seq.sv
// Scales a packed 3-component Q vector by a scalar using one shared multiplier.
// Build option: VECTOR_SCALE_ROUND_EN selects round-half-up instead of floor.
module vector_scale_seq
  import vec_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_scalar,
  input  logic [3*W-1:0] in_vector,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [3*W-1:0] out_vector,
  output logic           out_ovf
);
  logic [2:0]   state;
  vs_req_t      req_q;
  logic [W-1:0] comp;
  logic [W-1:0] r;
  logic         sat;

  // rst_n gating keeps in_ready low while reset is asserted
  assign in_ready  = rst_n && (state == S_IDLE);
  assign out_valid = (state == S_DONE);

  always_comb begin
    comp = '0;
    case (state)
      S_MX:    comp = req_q.vec[X_LSB +: W];
      S_MY:    comp = req_q.vec[Y_LSB +: W];
      S_MZ:    comp = req_q.vec[Z_LSB +: W];
      default: comp = '0;
    endcase
  end

  sat_mul_shift u_mul (
    .a   (req_q.scl),
    .b   (comp),
    .r   (r),
    .sat (sat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      req_q      <= '0;
      out_vector <= '0;
      out_ovf    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (in_valid) begin
          req_q   <= '{scl: in_scalar, vec: in_vector};
          out_ovf <= 1'b0;
          state   <= S_MX;
        end
        S_MX: begin
          out_vector[X_LSB +: W] <= r;
          out_ovf                <= out_ovf | sat;
          state                  <= S_MY;
        end
        S_MY: begin
          out_vector[Y_LSB +: W] <= r;
          out_ovf                <= out_ovf | sat;
          state                  <= S_MZ;
        end
        S_MZ: begin
          out_vector[Z_LSB +: W] <= r;
          out_ovf                <= out_ovf | sat;
          state                  <= S_DONE;
        end
        S_DONE: if (out_ready) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_vector_scale_seq.sv
// Directed bench for vector_scale_seq: latency, throughput, saturation, rounding,
// backpressure and mid-operation reset.
module tb_vector_scale_seq;
  import vec_pkg::*;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [W-1:0]   in_scalar = '0;
  logic [3*W-1:0] in_vector = '0;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic [3*W-1:0] out_vector;
  logic           out_ovf;

  int checks = 0;
  int failures = 0;

  vector_scale_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_scalar  (in_scalar),
    .in_vector  (in_vector),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_vector (out_vector),
    .out_ovf    (out_ovf)
  );

  always #5 clk = ~clk;

  function automatic logic [3*W-1:0] v3(input int x, input int y, input int z);
    logic [W-1:0] a, b, c;
    a = W'(x);
    b = W'(y);
    c = W'(z);
    return {a, b, c};
  endfunction

  task automatic chk(input string tag, input logic [3*W-1:0] obs, input logic [3*W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // call at a negedge; returns just after the accepting posedge
  task automatic send(input int s, input logic [3*W-1:0] v, output time t_acc);
    int n;
    n = 0;
    in_scalar = W'(s);
    in_vector = v;
    in_valid  = 1'b1;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("accept_ready", {56'd0, in_ready}, 57'd1);
    @(posedge clk);
    t_acc = $time;
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 20);
  endtask

  initial begin
    time t1, t2, td;
    int  lat;
    logic [3*W-1:0] exp5;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_out_valid", {56'd0, out_valid}, 57'd0);
    chk("rst_out_vector", out_vector, '0);
    chk("rst_out_ovf", {56'd0, out_ovf}, 57'd0);
    chk("rst_in_ready", {56'd0, in_ready}, 57'd0);
    rst_n = 1'b1;
    #1 chk("post_rst_in_ready", {56'd0, in_ready}, 57'd1);
    @(negedge clk);

    // 1: identity, latency 4
    send(256, v3(100, -200, 300), t1);
    wait_out(lat);
    chk("t1_latency", 57'(lat), 57'd4);
    chk("t1_vec", out_vector, v3(100, -200, 300));
    chk("t1_ovf", {56'd0, out_ovf}, 57'd0);

    // 2: scale by 2, back-to-back accept spacing
    send(512, v3(1000, -1000, 0), t2);
    td = (t2 - t1) / 10;
    chk("t2_accept_period", 57'(td), 57'd5);
    wait_out(lat);
    chk("t2_latency", 57'(lat), 57'd4);
    chk("t2_vec", out_vector, v3(2000, -2000, 0));
    chk("t2_ovf", {56'd0, out_ovf}, 57'd0);

    // 3: saturation both directions
    send(262143, v3(262143, -262144, 1), t1);
    wait_out(lat);
`ifdef VECTOR_SCALE_ROUND_EN
    chk("t3_vec", out_vector, v3(262143, -262144, 1024));
`else
    chk("t3_vec", out_vector, v3(262143, -262144, 1023));
`endif
    chk("t3_ovf", {56'd0, out_ovf}, 57'd1);

    // 4: rounding vs floor; ovf must clear from the previous result
    send(128, v3(3, -3, 1), t1);
    wait_out(lat);
`ifdef VECTOR_SCALE_ROUND_EN
    chk("t4_vec", out_vector, v3(2, -1, 1));
`else
    chk("t4_vec", out_vector, v3(1, -2, 0));
`endif
    chk("t4_ovf", {56'd0, out_ovf}, 57'd0);

    // zero scalar
    send(0, v3(5, -6, 7), t1);
    wait_out(lat);
    chk("zero_vec", out_vector, v3(0, 0, 0));
    chk("zero_ovf", {56'd0, out_ovf}, 57'd0);

    // 5: backpressure for 10 cycles with a stray in_valid pulse
    @(negedge clk);
    out_ready = 1'b0;
    send(768, v3(-5, 6, 100000), t1);
    wait_out(lat);
    exp5 = v3(-15, 18, 262143);
    chk("t5_latency", 57'(lat), 57'd4);
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        in_scalar = W'(1);
        in_vector = v3(9, 9, 9);
        in_valid  = 1'b1;
      end
      if (i == 4) in_valid = 1'b0;
      @(negedge clk);
      chk("t5_hold_vec", out_vector, exp5);
      chk("t5_hold_ovf", {56'd0, out_ovf}, 57'd1);
      chk("t5_hold_valid", {56'd0, out_valid}, 57'd1);
      chk("t5_hold_in_ready", {56'd0, in_ready}, 57'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("t5_rel_valid", {56'd0, out_valid}, 57'd0);
    chk("t5_rel_in_ready", {56'd0, in_ready}, 57'd1);
    chk("t5_rel_vec_kept", out_vector, exp5);

    // 6: reset during MY
    send(256, v3(1, 2, 3), t1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", {56'd0, out_valid}, 57'd0);
    chk("t6_rst_vec", out_vector, '0);
    chk("t6_rst_ovf", {56'd0, out_ovf}, 57'd0);
    chk("t6_rst_in_ready", {56'd0, in_ready}, 57'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("t6_post_in_ready", {56'd0, in_ready}, 57'd1);
    @(negedge clk);
    send(-256, v3(10, -20, 30), t1);
    wait_out(lat);
    chk("t6_latency", 57'(lat), 57'd4);
    chk("t6_vec", out_vector, v3(-10, 20, -30));
    chk("t6_ovf", {56'd0, out_ovf}, 57'd0);

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
